// File: rtl/system_client0_cpu_debug_cmd_decode_pkg.sv
// Shared constants for the CPU debug command decoder: IR codes, jdo field positions, widths.
package system_client0_cpu_debug_cmd_decode_pkg;

    localparam int JDO_W      = 38;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'b00,
        IR_SAMPLE    = 2'b01,
        IR_BREAK     = 2'b10,
        IR_TRACECTRL = 2'b11
    } ir_e;

    // jdo fields that steer the command decode
    localparam int JDO_ACT   = 37;
    localparam int JDO_SEL_H = 36;
    localparam int JDO_SEL_M = 35;
    localparam int JDO_SEL_L = 34;
    localparam int JDO_TRACE = 15;

endpackage

// File: rtl/system_client0_cpu_debug_cmd_decode_sync2.sv
// Multi-flop level synchronizer bringing a TCK-domain level into the clk domain.
module system_client0_cpu_debug_sync2 #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[DEPTH-2:0], d};
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/system_client0_cpu_debug_cmd_decode.sv
// Captures JTAG IR/DR updates into the clk domain and decodes them into one-cycle command pulses.
module system_client0_cpu_debug_cmd_decode
    import system_client0_cpu_debug_cmd_decode_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ir_in,
    input  logic [JDO_W-1:0] sr,
    input  logic             vs_uir,
    input  logic             vs_udr,
    output logic [JDO_W-1:0] jdo,
    output logic             take_action_ocimem_a,
    output logic             take_no_action_ocimem_a,
    output logic             take_action_ocimem_b,
    output logic             take_action_break_a,
    output logic             take_action_break_b,
    output logic             take_action_break_c,
    output logic             take_no_action_break_a,
    output logic             take_no_action_break_b,
    output logic             take_no_action_break_c,
    output logic             take_action_tracectrl
);

    logic sync_udr, sync_uir;
    logic hist_udr, hist_uir;
    logic udr_strobe, uir_strobe;
    logic enable_action;
    ir_e  ir;

    system_client0_cpu_debug_sync2 #(.DEPTH(SYNC_DEPTH)) u_sync_udr (
        .clk(clk), .reset(reset), .d(vs_udr), .q(sync_udr)
    );

    system_client0_cpu_debug_sync2 #(.DEPTH(SYNC_DEPTH)) u_sync_uir (
        .clk(clk), .reset(reset), .d(vs_uir), .q(sync_uir)
    );

    // Rising-edge detect: one strobe per update level, however long it is held.
    assign udr_strobe = sync_udr & ~hist_udr;
    assign uir_strobe = sync_uir & ~hist_uir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_udr      <= 1'b0;
            hist_uir      <= 1'b0;
            ir            <= IR_OCIMEM;
            jdo           <= '0;
            enable_action <= 1'b0;
        end else begin
            hist_udr      <= sync_udr;
            hist_uir      <= sync_uir;
            enable_action <= udr_strobe;
            if (uir_strobe) ir  <= ir_e'(ir_in);
            if (udr_strobe) jdo <= sr;
        end
    end

    // ir selects a disjoint decode group, so at most one pulse is ever high.
    always_comb begin
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_action_break_a     = 1'b0;
        take_action_break_b     = 1'b0;
        take_action_break_c     = 1'b0;
        take_no_action_break_a  = 1'b0;
        take_no_action_break_b  = 1'b0;
        take_no_action_break_c  = 1'b0;
        take_action_tracectrl   = 1'b0;
        if (enable_action) begin
            case (ir)
                IR_OCIMEM: begin
                    take_action_ocimem_a    = ~jdo[JDO_SEL_M] &  jdo[JDO_SEL_L];
                    take_no_action_ocimem_a = ~jdo[JDO_SEL_M] & ~jdo[JDO_SEL_L];
                    take_action_ocimem_b    =  jdo[JDO_SEL_M];
                end
                IR_BREAK: begin
                    take_action_break_a    =  jdo[JDO_ACT] & ~jdo[JDO_SEL_H];
                    take_action_break_b    =  jdo[JDO_ACT] &  jdo[JDO_SEL_H] & ~jdo[JDO_SEL_M];
                    take_action_break_c    =  jdo[JDO_ACT] &  jdo[JDO_SEL_H] &  jdo[JDO_SEL_M];
                    take_no_action_break_a = ~jdo[JDO_ACT] & ~jdo[JDO_SEL_H];
                    take_no_action_break_b = ~jdo[JDO_ACT] &  jdo[JDO_SEL_H] & ~jdo[JDO_SEL_M];
                    take_no_action_break_c = ~jdo[JDO_ACT] &  jdo[JDO_SEL_H] &  jdo[JDO_SEL_M];
                end
                IR_TRACECTRL: take_action_tracectrl = jdo[JDO_TRACE];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_system_client0_cpu_debug_cmd_decode.sv
// Directed bench for the CPU debug command decoder.
module tb_system_client0_cpu_debug_cmd_decode;

    logic        clk;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir, vs_udr;
    logic [37:0] jdo;
    logic t_oa, t_noa, t_ob, t_ba, t_bb, t_bc, t_nba, t_nbb, t_nbc, t_tc;
    logic [9:0]  take;

    int checks   = 0;
    int failures = 0;
    logic [37:0] cur_jdo;

    // Expected-pulse one-hots, bit order matches 'take'
    localparam logic [9:0] P_NONE = 10'd0;
    localparam logic [9:0] P_OA   = 10'b00_0000_0001;
    localparam logic [9:0] P_NOA  = 10'b00_0000_0010;
    localparam logic [9:0] P_OB   = 10'b00_0000_0100;
    localparam logic [9:0] P_BA   = 10'b00_0000_1000;
    localparam logic [9:0] P_BB   = 10'b00_0001_0000;
    localparam logic [9:0] P_NBC  = 10'b01_0000_0000;
    localparam logic [9:0] P_TC   = 10'b10_0000_0000;

    system_client0_cpu_debug_cmd_decode dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr), .jdo(jdo),
        .take_action_ocimem_a(t_oa), .take_no_action_ocimem_a(t_noa),
        .take_action_ocimem_b(t_ob),
        .take_action_break_a(t_ba), .take_action_break_b(t_bb), .take_action_break_c(t_bc),
        .take_no_action_break_a(t_nba), .take_no_action_break_b(t_nbb),
        .take_no_action_break_c(t_nbc),
        .take_action_tracectrl(t_tc)
    );

    assign take = {t_tc, t_nbc, t_nbb, t_nba, t_bc, t_bb, t_ba, t_ob, t_noa, t_oa};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_sr(input logic [3:0] top, input logic b15, input logic [33:0] fill);
        logic [37:0] r;
        r     = {top, fill};
        r[15] = b15;
        return r;
    endfunction

    // vs_udr went high just after an edge; the next edge is edge 1.
    task automatic watch(input string tag, input int hold, input logic [9:0] exp_take,
                         input logic [37:0] exp_jdo);
        logic [9:0] stray;
        stray = '0;
        for (int i = 1; i <= hold + 4; i++) begin
            @(posedge clk); #1;
            if (i == 2) chk({tag, "_jdo_early"}, jdo, cur_jdo);
            if (i == 3) begin
                chk({tag, "_take"}, take, exp_take);
                chk({tag, "_jdo"}, jdo, exp_jdo);
            end else begin
                stray |= take;
            end
            if (i == hold) begin
                vs_udr = 1'b0;
                vs_uir = 1'b0;
            end
        end
        chk({tag, "_single"}, stray, P_NONE);
        chk({tag, "_jdo_hold"}, jdo, exp_jdo);
        cur_jdo = exp_jdo;
    endtask

    task automatic send_dr(input string tag, input logic [37:0] s, input int hold,
                           input logic [9:0] exp_take);
        sr     = s;
        vs_udr = 1'b1;
        watch(tag, hold, exp_take, s);
    endtask

    task automatic load_ir(input string tag, input logic [1:0] code);
        logic [9:0] stray;
        stray  = '0;
        ir_in  = code;
        vs_uir = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) vs_uir = 1'b0;
            if (i == 3) chk({tag, "_ir"}, 64'(dut.ir), 64'(code));
            stray |= take;
        end
        chk({tag, "_nopulse"}, stray, P_NONE);
        chk({tag, "_jdo_hold"}, jdo, cur_jdo);
    endtask

    initial begin
        logic [37:0] s;
        logic [9:0]  stray;
        reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0; cur_jdo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_jdo", jdo, 38'd0);
        chk("rst_take", take, P_NONE);
        chk("rst_ir", 64'(dut.ir), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        load_ir("ir_oci", 2'b00);
        send_dr("oci_a",  mk_sr(4'b0001, 1'b0, 34'h2_DEAD_BEEF), 5, P_OA);
        send_dr("oci_na", mk_sr(4'b0000, 1'b1, 34'h1_2345_6789), 1, P_NOA);
        send_dr("oci_b",  mk_sr(4'b0010, 1'b0, 34'h0_0F0F_0F0F), 3, P_OB);

        load_ir("ir_brk", 2'b10);
        send_dr("brk_b",  mk_sr(4'b1100, 1'b0, 34'h3_FFFF_0000), 2, P_BB);
        send_dr("brk_nc", mk_sr(4'b0110, 1'b1, 34'h0_5555_AAAA), 2, P_NBC);

        load_ir("ir_tc", 2'b11);
        send_dr("tc_on",  mk_sr(4'b1111, 1'b1, 34'h0_0000_0000), 2, P_TC);
        send_dr("tc_off", mk_sr(4'b1111, 1'b0, 34'h3_FFFF_FFFF), 2, P_NONE);

        load_ir("ir_smp", 2'b01);
        send_dr("smp",    mk_sr(4'b1010, 1'b1, 34'h2_AAAA_5555), 2, P_NONE);

        // Both updates together: the decode must see the freshly loaded BREAK code.
        s      = mk_sr(4'b1000, 1'b0, 34'h1_CAFE_F00D);
        sr     = s;
        ir_in  = 2'b10;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        watch("both", 2, P_BA, s);
        chk("both_ir", 64'(dut.ir), 64'd2);

        // vs_udr held high through reset release: one pulse with ir back at OCIMEM.
        reset = 1'b1;
        @(posedge clk); #1;
        s      = mk_sr(4'b0001, 1'b1, 34'h0_1357_9BDF);
        sr     = s;
        vs_udr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rsthold_take", take, P_NONE);
        chk("rsthold_jdo", jdo, 38'd0);
        cur_jdo = '0;
        reset   = 1'b0;
        watch("rsthold", 3, P_OA, s);

        // Reset one edge after vs_udr rises cancels the pending strobe.
        sr     = mk_sr(4'b0010, 1'b0, 34'h2_4680_ACE0);
        vs_udr = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_jdo", jdo, 38'd0);
        chk("midrst_take", take, P_NONE);
        vs_udr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        stray = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            stray |= take;
        end
        chk("midrst_nopulse", stray, P_NONE);
        chk("midrst_jdo_after", jdo, 38'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/system_client0_cpu_debug_cmd_decode.md
SYSTEM_CLIENT0_CPU_DEBUG_CMD_DECODE -- requirements
Module: system_client0_cpu_debug_cmd_decode

Interface
REQ-001 clk  input  1  system clock; the only clock in the block; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 ir_in  input  2  JTAG instruction from the TCK domain; stable while vs_uir is high.
REQ-004 sr  input  38  JTAG shift-register contents from the TCK domain; stable while vs_udr is high.
REQ-005 vs_uir  input  1  update-IR level from the TCK domain; asynchronous to clk.
REQ-006 vs_udr  input  1  update-DR level from the TCK domain; asynchronous to clk.
REQ-007 jdo  output  38  sr captured into the clk domain.
REQ-008 take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b  output  1 each  OCI memory command pulses.
REQ-009 take_action_break_a/b/c, take_no_action_break_a/b/c  output  1 each  break-register command pulses.
REQ-010 take_action_tracectrl  output  1  trace-control command pulse.

Function
REQ-011 vs_udr and vs_uir SHALL each pass through a 2-flop synchronizer, followed by one history flop, for edge detection.
REQ-012 The udr strobe SHALL equal sync2_udr AND NOT hist_udr; the uir strobe SHALL be formed the same way from the uir chain.
REQ-013 Latency, udr path: edge 1 is the first clk edge that samples vs_udr=1.
  - jdo loads sr at edge 3.
  - Registered enable_action is high from edge 3 to edge 4.
REQ-014 Latency, uir path: the ir register loads ir_in at edge 3, counted the same way.
REQ-015 Each low-to-high transition of vs_udr SHALL produce exactly one enable_action cycle, however long vs_udr stays high.
REQ-016 jdo and ir SHALL hold their values between strobes.
REQ-017 take_* outputs SHALL be combinational decodes of (enable_action, ir, jdo), so each is a single-cycle pulse.
REQ-018 Decodes with ir=00:
  - ocimem_a: jdo[35]=0 and jdo[34]=1.
  - no_action_ocimem_a: jdo[35]=0 and jdo[34]=0.
  - ocimem_b: jdo[35]=1.
REQ-019 Decodes with ir=10 (take_action when jdo[37]=1, take_no_action when jdo[37]=0):
  - break_a: jdo[36]=0.
  - break_b: jdo[36]=1 and jdo[35]=0.
  - break_c: jdo[36]=1 and jdo[35]=1.
REQ-020 Decode with ir=11: take_action_tracectrl when jdo[15]=1.
REQ-021 ir=01 (sample) SHALL generate no pulse.
REQ-022 At most one take_* output SHALL be high in any cycle.
REQ-023 Simultaneous uir and udr strobes SHALL load ir and jdo on the same edge; the decode SHALL use the new ir.
REQ-024 A uir strobe without a udr strobe SHALL update ir only and produce no pulse.
REQ-025 A vs_udr pulse shorter than one clk period SHALL be either missed entirely or produce exactly one strobe, never two.

Reset
REQ-026 While reset is high, the following SHALL be 0 asynchronously:
  - all synchronizer and history flops;
  - ir, jdo and enable_action;
  - every take_* output.
REQ-027 If vs_udr or vs_uir is held high through reset release, exactly one strobe SHALL follow, 2 edges after release.
REQ-028 Reset asserted mid-operation SHALL cancel any pending strobe; no take_* pulse SHALL appear after reset deasserts unless REQ-027 applies.

Structure
REQ-029 A shared package SHALL hold:
  - IR codes: OCIMEM=2'b00, SAMPLE=2'b01, BREAK=2'b10, TRACECTRL=2'b11;
  - jdo bit-index constants 37, 36, 35, 34, 15;
  - JDO_W=38.
REQ-030 The synchronizer SHALL be one sub-module, system_client0_cpu_debug_sync2: parameterized depth (default 2), async active-high reset, instantiated twice.

Verification
REQ-031 Directed scenarios the bench SHALL cover:
  - ir_in=00, pulse vs_uir; sr[35:34]=01, pulse vs_udr for 5 clks -> ir=00 after 3 edges; take_action_ocimem_a high exactly 1 cycle, 3 edges after vs_udr sampled high; jdo=sr.
  - ir=10, sr[37:35]=110 -> take_action_break_b only; repeat with sr[37:35]=011 -> take_no_action_break_c only.
  - ir=11, sr[15]=1 then sr[15]=0 -> one tracectrl pulse, then none; jdo[15] tracks the captured value.
  - ir=01, any sr -> jdo updates, all take_* stay 0.
  - vs_uir and vs_udr rise on the same clk with ir_in=10, sr[37:36]=10 -> take_action_break_a asserted, using the new ir.
  - vs_udr held high across reset deassert -> one pulse 2 edges after release; assert reset 1 edge after vs_udr rises -> no pulse and all outputs 0.
